joypad_port: RTL and testbench
==============================

Name: joypad_port

Overview:
- CPU-side controller port logic for $4016/$4017.
- Decodes CPU bus accesses and drives the strobe and read-clock inputs of two serial controllers (player 1 and player 2).
- Samples each controller's serial data bit and returns it on the CPU read bus with NES-accurate open-bus upper bits.
- Sits between the CPU/bus arbiter and the two controller shift-register models (or real pad pins).

Parameters:
- ADDR_P1, 16'h4016, CPU address for the strobe write and the player 1 read.
- ADDR_P2, 16'h4017, CPU address for the player 2 read; writes to it are ignored here because they belong to the APU frame counter.
- RD_PULSE_CYC, 1, width in clk cycles of each rd1/rd2 pulse (1..4).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cpu_ce  in  1  one-clk CPU cycle enable; bus signals are valid only when high
- addr  in  16  CPU address
- cpu_wr  in  1  CPU write strobe, qualified by cpu_ce
- cpu_rd  in  1  CPU read strobe, qualified by cpu_ce
- din  in  8  CPU write data
- open_bus  in  8  last value seen on the CPU data bus
- dmc_dma  in  1  DMC DMA steal in progress; used only with the optional feature
- dout  out  8  read data
- dout_valid  out  1  one-clk pulse when dout has been updated
- strobe  out  1  controller latch, to both pads
- rd1  out  1  player 1 read clock
- rd2  out  1  player 2 read clock
- data1  in  1  player 1 serial data, active-high button bit as presented by the pad
- data2  in  1  player 2 serial data
- cnt1  out  4  player 1 bits read since the last strobe, saturating at 8
- cnt2  out  4  player 2 bits read since the last strobe, saturating at 8

Behaviour:
- Reset values: strobe=0, rd1=0, rd2=0, dout=0, dout_valid=0, cnt1=0, cnt2=0, FSM=IDLE.
- Write decode: when cpu_ce & cpu_wr & addr==ADDR_P1, strobe <= din[0] on that edge. Other din bits are ignored.
- Strobe effect on counters: while strobe=1, cnt1 and cnt2 are held at 0. A read while strobe=1 still pulses rd and returns data.
- Read decode: when cpu_ce & cpu_rd & addr==ADDR_P1 (or ADDR_P2), the FSM leaves IDLE and selects the port.
- FSM states: IDLE, SAMPLE, PULSE, GAP.
- IDLE -> SAMPLE on a decoded read.
- SAMPLE lasts 1 clk. It registers dout = {open_bus[7:5], 4'b0000, dataN} using the pre-shift data bit, sets dout_valid=1 for that one edge, and increments cntN (saturating at 8; 8 stays 8).
- SAMPLE -> PULSE. rdN=1 for RD_PULSE_CYC clks, so the pad shifts after the sample has been taken.
- PULSE -> IDLE (or -> GAP with the optional feature).
- Latency: dout is valid 1 clk after the cpu_ce access cycle. rdN rises 2 clks after the access.
- dout holds its value until the next read.
- New decoded reads arriving while the FSM is not IDLE are dropped. The CPU cannot issue reads that close together, so this is a protocol violation.
- A write to ADDR_P1 coinciding with PULSE is accepted. strobe updates immediately and the pulse completes.
- rd1 and rd2 are never high simultaneously.
- cpu_rd and cpu_wr both asserted in the same cycle: the write takes priority and no read is started.
- Reset mid-pulse: rdN drops on the reset edge and no further pulse is emitted.

Optional Feature:
- Macro: JOYPAD_DMC_GLITCH_EN.
- When defined: if dmc_dma=1 during the access cycle of a decoded read, PULSE -> GAP (1 clk, rdN=0) -> PULSE again. The pad therefore receives two read clocks and the counter increments twice (saturating). Only one dout_valid pulse is emitted, and it carries the first-sampled bit. This models the 2A03 DPCM double-read bit-deletion bug.
- When not defined: dmc_dma is ignored, the GAP state is absent, and every read produces exactly one rd pulse.

Test Plan:
- Reset, then write din=8'h01 and then din=8'h00 to $4016 -> strobe goes 1 then 0; cnt1=cnt2=0.
- Pad 1 latched with btns=8'b1000_0101 (sim model returns inverted bits); eight $4016 reads with open_bus=8'h40 -> dout sequence 8'h40|{~bit0..~bit7}, i.e. D0=0,1,0,1,1,1,1,0; cnt1 ends at 8.
- Two further $4016 reads -> D0=1 both times; cnt1 stays 8; rd1 pulses still issued; rd2 never asserts.
- Interleave $4016/$4017 reads -> each port's bit order is independent; rdN rises exactly 2 clks after its access; dout_valid is a single 1-clk pulse per read.
- Assert rst during PULSE with RD_PULSE_CYC=3 -> rd1=0 on the next edge; all outputs at their reset values; the next read behaves normally.
- With JOYPAD_DMC_GLITCH_EN defined, a $4016 read with dmc_dma=1 -> two rd1 pulses separated by 1 clk, cnt1 advances by 2, one dout_valid pulse; the same read with the macro undefined -> one pulse, cnt1 advances by 1.

Source files
------------

// File: rtl/joypad_port_if.sv
// CPU-side bus bundle for the $4016/$4017 controller port: access qualifiers in, read data out.
interface joypad_port_if;
    logic        cpu_ce;
    logic [15:0] addr;
    logic        cpu_wr;
    logic        cpu_rd;
    logic [7:0]  din;
    logic [7:0]  open_bus;
    logic        dmc_dma;
    logic [7:0]  dout;
    logic        dout_valid;

    modport master (
        output cpu_ce, addr, cpu_wr, cpu_rd, din, open_bus, dmc_dma,
        input  dout, dout_valid
    );

    modport slave (
        input  cpu_ce, addr, cpu_wr, cpu_rd, din, open_bus, dmc_dma,
        output dout, dout_valid
    );
endinterface

// File: rtl/joypad_port.sv
// $4016/$4017 controller port: strobe latch, per-read sample + rd pulse FSM, open-bus read data.
// Optional JOYPAD_DMC_GLITCH_EN models the 2A03 DPCM double-read (second rd pulse via GAP).
module joypad_port #(
    parameter logic [15:0] ADDR_P1      = 16'h4016,
    parameter logic [15:0] ADDR_P2      = 16'h4017,
    parameter int unsigned RD_PULSE_CYC = 1
) (
    input  logic         clk,
    input  logic         rst,
    joypad_port_if.slave bus,
    output logic         strobe,
    output logic         rd1,
    output logic         rd2,
    input  logic         data1,
    input  logic         data2,
    output logic [3:0]   cnt1,
    output logic [3:0]   cnt2
);

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        PULSE
`ifdef JOYPAD_DMC_GLITCH_EN
        , GAP
`endif
    } state_t;

    localparam logic [1:0] PULSE_LAST = 2'(RD_PULSE_CYC - 1);

    state_t      state;
    state_t      state_nxt;
    logic        sel_p2;
    logic [1:0]  pcnt;

    logic        wr_hit;
    logic        rd_hit;
    logic        strobe_nxt;

    logic        start;
    logic        sample;
    logic        load_pcnt;
    logic        dec_pcnt;
    logic        extra_inc;

    logic        inc1;
    logic        inc2;

`ifdef JOYPAD_DMC_GLITCH_EN
    logic        glitch;
    logic        second;
`else
    logic        unused_dma;
    assign unused_dma = bus.dmc_dma;
`endif

    logic        unused_bits;
    assign unused_bits = ^{bus.din[7:1], bus.open_bus[4:0]};

    function automatic logic [3:0] sat_inc(input logic [3:0] c);
        return (c >= 4'd8) ? 4'd8 : c + 4'd1;
    endfunction

    // A simultaneous write wins: it suppresses any read start in the same cycle.
    assign wr_hit = bus.cpu_ce & bus.cpu_wr & (bus.addr == ADDR_P1);
    assign rd_hit = bus.cpu_ce & bus.cpu_rd & ~bus.cpu_wr
                  & ((bus.addr == ADDR_P1) | (bus.addr == ADDR_P2));

    assign strobe_nxt = wr_hit ? bus.din[0] : strobe;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        sample    = 1'b0;
        load_pcnt = 1'b0;
        dec_pcnt  = 1'b0;
        extra_inc = 1'b0;
        case (state)
            IDLE: begin
                if (rd_hit) begin
                    state_nxt = SAMPLE;
                    start     = 1'b1;
                end
            end
            SAMPLE: begin
                sample    = 1'b1;
                load_pcnt = 1'b1;
                state_nxt = PULSE;
            end
            PULSE: begin
                if (pcnt == 2'd0) begin
`ifdef JOYPAD_DMC_GLITCH_EN
                    if (glitch && !second) begin
                        state_nxt = GAP;
                    end else begin
                        state_nxt = IDLE;
                    end
`else
                    state_nxt = IDLE;
`endif
                end else begin
                    dec_pcnt = 1'b1;
                end
            end
`ifdef JOYPAD_DMC_GLITCH_EN
            GAP: begin
                load_pcnt = 1'b1;
                extra_inc = 1'b1;
                state_nxt = PULSE;
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign inc1 = (sample | extra_inc) & ~sel_p2;
    assign inc2 = (sample | extra_inc) &  sel_p2;

    // rd is registered off the state, so it trails PULSE by one clk and rises two clks after the access.
    always_ff @(posedge clk) begin
        if (rst) begin
            strobe         <= 1'b0;
            sel_p2         <= 1'b0;
            pcnt           <= '0;
            rd1            <= 1'b0;
            rd2            <= 1'b0;
            cnt1           <= '0;
            cnt2           <= '0;
            bus.dout       <= '0;
            bus.dout_valid <= 1'b0;
`ifdef JOYPAD_DMC_GLITCH_EN
            glitch         <= 1'b0;
            second         <= 1'b0;
`endif
        end else begin
            strobe <= strobe_nxt;

            if (start) begin
                sel_p2 <= (bus.addr == ADDR_P2);
            end

            if (load_pcnt) begin
                pcnt <= PULSE_LAST;
            end else if (dec_pcnt) begin
                pcnt <= pcnt - 2'd1;
            end

            bus.dout_valid <= sample;
            if (sample) begin
                bus.dout <= {bus.open_bus[7:5], 4'b0000, (sel_p2 ? data2 : data1)};
            end

            rd1 <= (state == PULSE) & ~sel_p2;
            rd2 <= (state == PULSE) &  sel_p2;

            if (strobe_nxt) begin
                cnt1 <= '0;
            end else if (inc1) begin
                cnt1 <= sat_inc(cnt1);
            end

            if (strobe_nxt) begin
                cnt2 <= '0;
            end else if (inc2) begin
                cnt2 <= sat_inc(cnt2);
            end

`ifdef JOYPAD_DMC_GLITCH_EN
            if (start) begin
                glitch <= bus.dmc_dma;
                second <= 1'b0;
            end else if (extra_inc) begin
                second <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_joypad_port.sv
// Directed + randomized bench for joypad_port: pad shift-register models and a read-index reference model.
module tb_joypad_port;

    localparam int unsigned PW = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       strobe;
    logic       rd1;
    logic       rd2;
    logic       data1;
    logic       data2;
    logic [3:0] cnt1;
    logic [3:0] cnt2;

    joypad_port_if bus ();

    joypad_port #(
        .ADDR_P1     (16'h4016),
        .ADDR_P2     (16'h4017),
        .RD_PULSE_CYC(PW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .strobe(strobe),
        .rd1   (rd1),
        .rd2   (rd2),
        .data1 (data1),
        .data2 (data2),
        .cnt1  (cnt1),
        .cnt2  (cnt2)
    );

    always #5 clk = ~clk;

    // Pads: latch inverted buttons while strobe is high, shift on rd rising edge, fill with 1s.
    logic [7:0] btn1 = 8'h00;
    logic [7:0] btn2 = 8'h00;
    logic [7:0] sh1  = 8'hFF;
    logic [7:0] sh2  = 8'hFF;
    logic       rd1_q = 1'b0;
    logic       rd2_q = 1'b0;

    always @(posedge clk) begin
        rd1_q <= rd1;
        rd2_q <= rd2;
        if (strobe) sh1 <= ~btn1;
        else if (rd1 && !rd1_q) sh1 <= {1'b1, sh1[7:1]};
        if (strobe) sh2 <= ~btn2;
        else if (rd2 && !rd2_q) sh2 <= {1'b1, sh2[7:1]};
    end

    assign data1 = sh1[0];
    assign data2 = sh2[0];

    int   total = 0;
    int   bad   = 0;
    int   kp[2];
    int   cm[2];
    logic strobe_m;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int sat8(input int v);
        return (v > 8) ? 8 : v;
    endfunction

    function automatic logic exp_bit(input int p);
        logic [7:0] b;
        b = (p == 0) ? btn1 : btn2;
        if (strobe_m) return ~b[0];
        if (kp[p] < 8) return ~b[kp[p]];
        return 1'b1;
    endfunction

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.cpu_ce = 1'b1; bus.cpu_wr = 1'b1; bus.addr = a; bus.din = d;
        @(negedge clk);
        bus.cpu_ce = 1'b0; bus.cpu_wr = 1'b0;
        if (a == 16'h4016) begin
            strobe_m = d[0];
            if (d[0]) begin
                kp = '{0, 0};
                cm = '{0, 0};
            end
        end
        chk("wr_strobe", strobe, strobe_m);
        chk("wr_cnt1", cnt1, 8'(cm[0]));
        chk("wr_cnt2", cnt2, 8'(cm[1]));
    endtask

    task automatic do_read(input int p, input logic dma, input logic mid_wr);
        logic [7:0] ob;
        logic [7:0] exp_d;
        int         exp_inc;
        int         pulses;
        int         hi;
        int         other;
        int         dv;
        logic       prev;
        logic       cur;
        ob = 8'($urandom);
`ifdef JOYPAD_DMC_GLITCH_EN
        exp_inc = dma ? 2 : 1;
`else
        exp_inc = 1;
`endif
        @(negedge clk);
        bus.cpu_ce = 1'b1; bus.cpu_rd = 1'b1; bus.open_bus = ob; bus.dmc_dma = dma;
        bus.addr = (p == 0) ? 16'h4016 : 16'h4017;
        exp_d = {ob[7:5], 4'b0000, exp_bit(p)};
        @(negedge clk);
        bus.cpu_ce = 1'b0; bus.cpu_rd = 1'b0; bus.dmc_dma = 1'b0;
        chk("dv_early", bus.dout_valid, 1'b0);
        chk("rd_early", rd1 | rd2, 1'b0);
        @(negedge clk);
        chk("dv_pulse", bus.dout_valid, 1'b1);
        chk("dout", bus.dout, exp_d);
        chk("cnt_sample", (p == 0) ? cnt1 : cnt2, 8'(strobe_m ? 0 : sat8(cm[p] + 1)));
        chk("rd_not_yet", rd1 | rd2, 1'b0);
        bus.open_bus = 8'($urandom);
        @(negedge clk);
        chk("rd_rise", (p == 0) ? rd1 : rd2, 1'b1);
        chk("dout_hold", bus.dout, exp_d);
        pulses = 1; hi = 1; prev = 1'b1; other = 0; dv = 0;
        for (int i = 0; i < int'(2 * PW + 4); i++) begin
            if (mid_wr && i == 0) begin
                bus.cpu_ce = 1'b1; bus.cpu_wr = 1'b1; bus.addr = 16'h4016; bus.din = 8'h01;
            end
            @(negedge clk);
            if (mid_wr && i == 0) begin
                bus.cpu_ce = 1'b0; bus.cpu_wr = 1'b0;
                strobe_m = 1'b1;
                chk("mid_wr_strobe", strobe, 1'b1);
            end
            cur = (p == 0) ? rd1 : rd2;
            if (cur && !prev) pulses++;
            if (cur) hi++;
            prev = cur;
            if ((p == 0) ? rd2 : rd1) other++;
            if (bus.dout_valid) dv++;
        end
        if (strobe_m) begin
            kp = '{0, 0};
            cm = '{0, 0};
        end else begin
            kp[p] += exp_inc;
            cm[p] = sat8(cm[p] + exp_inc);
        end
        chk("rd_pulses", 8'(pulses), 8'(exp_inc));
        chk("rd_width", 8'(hi), 8'(exp_inc * int'(PW)));
        chk("rd_excl", 8'(other), 8'h00);
        chk("dv_single", 8'(dv), 8'h00);
        chk("cnt_final", (p == 0) ? cnt1 : cnt2, 8'(cm[p]));
    endtask

    initial begin
        int cnt_hi;
        int dv_cnt;
        bus.cpu_ce = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_rd = 1'b0;
        bus.addr = '0; bus.din = '0; bus.open_bus = '0; bus.dmc_dma = 1'b0;
        kp = '{0, 0}; cm = '{0, 0}; strobe_m = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_strobe", strobe, 1'b0);
        chk("rst_rd", {rd1, rd2}, 2'b00);
        chk("rst_dout", bus.dout, 8'h00);
        chk("rst_dv", bus.dout_valid, 1'b0);
        chk("rst_cnt", {cnt1, cnt2}, 8'h00);
        rst = 1'b0;

        // Directed latch and full sequence on pad 1
        btn1 = 8'b1000_0101;
        btn2 = 8'($urandom);
        cpu_write(16'h4016, 8'h01);
        cpu_write(16'h4016, 8'h00);
        for (int i = 0; i < 8; i++) do_read(0, 1'b0, 1'b0);
        do_read(0, 1'b0, 1'b0);
        do_read(0, 1'b0, 1'b0);

        cpu_write(16'h4017, 8'h01);

        // Randomized interleave, with DMC DMA randomly asserted
        btn1 = 8'($urandom);
        btn2 = 8'($urandom);
        cpu_write(16'h4016, 8'hFF);
        cpu_write(16'h4016, 8'hFE);
        for (int i = 0; i < 24; i++) do_read(int'($urandom_range(1, 0)), 1'($urandom), 1'b0);

        // Reads while strobe is held high
        cpu_write(16'h4016, 8'h01);
        do_read(0, 1'b0, 1'b0);
        do_read(1, 1'b0, 1'b0);
        do_read(0, 1'b0, 1'b0);
        cpu_write(16'h4016, 8'h00);

        // Strobe write landing during a pulse
        do_read(1, 1'b0, 1'b0);
        do_read(1, 1'b0, 1'b1);
        cpu_write(16'h4016, 8'h00);

        // Read and write in the same cycle: write wins
        @(negedge clk);
        bus.cpu_ce = 1'b1; bus.cpu_rd = 1'b1; bus.cpu_wr = 1'b1; bus.addr = 16'h4016; bus.din = 8'h01;
        @(negedge clk);
        bus.cpu_ce = 1'b0; bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0;
        strobe_m = 1'b1; kp = '{0, 0}; cm = '{0, 0};
        chk("rw_strobe", strobe, 1'b1);
        cnt_hi = 0; dv_cnt = 0;
        for (int i = 0; i < int'(2 * PW + 4); i++) begin
            @(negedge clk);
            if (rd1 | rd2) cnt_hi++;
            if (bus.dout_valid) dv_cnt++;
        end
        chk("rw_no_rd", 8'(cnt_hi), 8'h00);
        chk("rw_no_dv", 8'(dv_cnt), 8'h00);
        cpu_write(16'h4016, 8'h00);
        do_read(0, 1'b0, 1'b0);

        // Reset during PULSE
        @(negedge clk);
        bus.cpu_ce = 1'b1; bus.cpu_rd = 1'b1; bus.addr = 16'h4016; bus.open_bus = 8'($urandom);
        @(negedge clk);
        bus.cpu_ce = 1'b0; bus.cpu_rd = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rstp_rd_hi", rd1, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        kp[0] += 1;
        cm = '{0, 0};
        chk("rstp_rd", {rd1, rd2}, 2'b00);
        chk("rstp_strobe", strobe, 1'b0);
        chk("rstp_dout", bus.dout, 8'h00);
        chk("rstp_dv", bus.dout_valid, 1'b0);
        chk("rstp_cnt", {cnt1, cnt2}, 8'h00);
        cnt_hi = 0;
        for (int i = 0; i < int'(2 * PW + 2); i++) begin
            @(negedge clk);
            if (rd1 | rd2) cnt_hi++;
        end
        chk("rstp_no_pulse", 8'(cnt_hi), 8'h00);
        do_read(0, 1'b0, 1'b0);
        do_read(1, 1'b0, 1'b0);

        // Directed DMC DMA read on a fresh latch
        cpu_write(16'h4016, 8'h01);
        cpu_write(16'h4016, 8'h00);
        do_read(0, 1'b1, 1'b0);
        do_read(0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
